// File: rtl/brom_arbiter.sv
// Boot-ROM read-port arbiter: round-robin between instruction fetch (IF) and
// data load (LD), with range/alignment checking and 1-cycle registered responses.

package config_pkg;
    typedef struct packed {
        int unsigned XLEN;
        logic [63:0] BOOTROM_BASE;
        logic [63:0] BOOTROM_RANGE;
    } config_t;

    localparam config_t DEFAULT_CONFIG = '{
        XLEN:          32,
        BOOTROM_BASE:  64'h0000_0000_8000_0000,
        BOOTROM_RANGE: 64'h0000_0000_0000_1000
    };
endpackage

module brom_arbiter #(
    parameter config_pkg::config_t CONF = config_pkg::DEFAULT_CONFIG,
    parameter int CNT_W = 16,
    localparam int XLEN = int'(CONF.XLEN)
) (
    input  logic             clk,
    input  logic             rst,
    // Handshake rule for every channel below: a transfer happens on a posedge
    // where valid and ready are both high; a valid side holds its payload
    // stable until it sees ready.
    input  logic             if_req_valid,
    output logic             if_req_ready,
    input  logic [XLEN-1:0]  if_req_addr,
    output logic             if_rsp_valid,
    input  logic             if_rsp_ready,
    output logic [XLEN-1:0]  if_rsp_data,
    output logic             if_rsp_err,
    input  logic             ld_req_valid,
    output logic             ld_req_ready,
    input  logic [XLEN-1:0]  ld_req_addr,
    output logic             ld_rsp_valid,
    input  logic             ld_rsp_ready,
    output logic [XLEN-1:0]  ld_rsp_data,
    output logic             ld_rsp_err,
    output logic [XLEN-1:0]  mem_addr,
    input  logic [XLEN-1:0]  mem_data,
    output logic [CNT_W-1:0] conflict_cnt
);

    typedef enum logic {
        GRANT_IF = 1'b0,
        GRANT_LD = 1'b1
    } grant_e;

    // Window bounds carried one bit wider so BASE + RANGE cannot wrap.
    localparam logic [XLEN:0] BASE_X  = {1'b0, CONF.BOOTROM_BASE[XLEN-1:0]};
    localparam logic [XLEN:0] RANGE_X = {1'b0, CONF.BOOTROM_RANGE[XLEN-1:0]};
    localparam logic [XLEN:0] END_X   = BASE_X + RANGE_X;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    grant_e          last_grant;
    logic            if_elig;
    logic            ld_elig;
    logic            both_elig;
    logic            grant_if;
    logic            grant_ld;
    logic [XLEN-1:0] sel_addr;
    logic [XLEN:0]   sel_addr_x;
    logic            fault;
    logic [XLEN-1:0] rd_data;

    // A port may be granted when its response slot is empty or drains now.
    always_comb begin
        if_elig   = if_req_valid && (!if_rsp_valid || if_rsp_ready);
        ld_elig   = ld_req_valid && (!ld_rsp_valid || ld_rsp_ready);
        both_elig = if_elig && ld_elig;
        grant_if  = !rst && if_elig && (!ld_elig || (last_grant == GRANT_LD));
        grant_ld  = !rst && ld_elig && (!if_elig || (last_grant == GRANT_IF));
    end

    assign if_req_ready = grant_if;
    assign ld_req_ready = grant_ld;

    always_comb begin
        sel_addr   = grant_ld ? ld_req_addr : if_req_addr;
        sel_addr_x = {1'b0, sel_addr};
        fault      = (sel_addr_x < BASE_X) || (sel_addr_x >= END_X) ||
                     (sel_addr[1:0] != 2'b00);
        mem_addr   = ((grant_if || grant_ld) && !fault) ? sel_addr : '0;
        // Faulting accesses return zero, never whatever the ROM drives.
        rd_data    = fault ? '0 : mem_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant   <= GRANT_LD;
            conflict_cnt <= '0;
        end else begin
            if (grant_if) begin
                last_grant <= GRANT_IF;
            end else if (grant_ld) begin
                last_grant <= GRANT_LD;
            end
            if (both_elig && (conflict_cnt != CNT_MAX)) begin
                conflict_cnt <= conflict_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            if_rsp_valid <= 1'b0;
            if_rsp_data  <= '0;
            if_rsp_err   <= 1'b0;
        end else if (grant_if) begin
            if_rsp_valid <= 1'b1;
            if_rsp_data  <= rd_data;
            if_rsp_err   <= fault;
        end else if (if_rsp_ready) begin
            if_rsp_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ld_rsp_valid <= 1'b0;
            ld_rsp_data  <= '0;
            ld_rsp_err   <= 1'b0;
        end else if (grant_ld) begin
            ld_rsp_valid <= 1'b1;
            ld_rsp_data  <= rd_data;
            ld_rsp_err   <= fault;
        end else if (ld_rsp_ready) begin
            ld_rsp_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_brom_arbiter.sv
// Bench for brom_arbiter: directed scenarios plus a constrained-random phase,
// with a cycle model and response scoreboard sampled on the falling edge.

module tb_brom_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic        if_req_valid = 1'b0, if_rsp_ready = 1'b1;
    logic        ld_req_valid = 1'b0, ld_rsp_ready = 1'b1;
    logic [31:0] if_req_addr = 32'h8000_0000, ld_req_addr = 32'h8000_0000;
    logic        if_req_ready, if_rsp_valid, if_rsp_err;
    logic        ld_req_ready, ld_rsp_valid, ld_rsp_err;
    logic [31:0] if_rsp_data, ld_rsp_data, mem_addr, mem_data;
    logic [15:0] conflict_cnt;

    logic        if_req_valid2 = 1'b0, ld_req_valid2 = 1'b0;
    logic        if_req_ready2, if_rsp_valid2, if_rsp_err2;
    logic        ld_req_ready2, ld_rsp_valid2, ld_rsp_err2;
    logic [31:0] if_rsp_data2, ld_rsp_data2, mem_addr2, mem_data2;
    logic [1:0]  conflict_cnt2;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        return (a == 32'h8000_0000) ? 32'h0000_0297 : {a[15:0] ^ 16'h5a5a, ~a[15:0]};
    endfunction

    function automatic logic addr_ok(input logic [31:0] a);
        return (a >= 32'h8000_0000) && (a < 32'h8000_1000) && (a[1:0] == 2'b00);
    endfunction

    function automatic logic [32:0] exp_rsp(input logic [31:0] a);
        return addr_ok(a) ? {1'b0, rom_word(a)} : {1'b1, 32'h0};
    endfunction

    function automatic logic [31:0] pick_addr();
        case ($urandom_range(0, 5))
            3:       return 32'h8000_1000;
            4:       return 32'h7FFF_FFFC;
            5:       return 32'h8000_0002;
            default: return 32'h8000_0000 + ($urandom_range(0, 1023) << 2);
        endcase
    endfunction

    assign mem_data  = rom_word(mem_addr);
    assign mem_data2 = rom_word(mem_addr2);

    brom_arbiter dut (
        .clk(clk), .rst(rst),
        .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_req_addr(if_req_addr),
        .if_rsp_valid(if_rsp_valid), .if_rsp_ready(if_rsp_ready),
        .if_rsp_data(if_rsp_data), .if_rsp_err(if_rsp_err),
        .ld_req_valid(ld_req_valid), .ld_req_ready(ld_req_ready), .ld_req_addr(ld_req_addr),
        .ld_rsp_valid(ld_rsp_valid), .ld_rsp_ready(ld_rsp_ready),
        .ld_rsp_data(ld_rsp_data), .ld_rsp_err(ld_rsp_err),
        .mem_addr(mem_addr), .mem_data(mem_data), .conflict_cnt(conflict_cnt)
    );

    brom_arbiter #(.CNT_W(2)) dut2 (
        .clk(clk), .rst(rst),
        .if_req_valid(if_req_valid2), .if_req_ready(if_req_ready2), .if_req_addr(32'h8000_0040),
        .if_rsp_valid(if_rsp_valid2), .if_rsp_ready(1'b1),
        .if_rsp_data(if_rsp_data2), .if_rsp_err(if_rsp_err2),
        .ld_req_valid(ld_req_valid2), .ld_req_ready(ld_req_ready2), .ld_req_addr(32'h8000_0080),
        .ld_rsp_valid(ld_rsp_valid2), .ld_rsp_ready(1'b1),
        .ld_rsp_data(ld_rsp_data2), .ld_rsp_err(ld_rsp_err2),
        .mem_addr(mem_addr2), .mem_data(mem_data2), .conflict_cnt(conflict_cnt2)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model state
    logic [32:0] exp_if_q[$];
    logic [32:0] exp_ld_q[$];
    logic        m_if_occ, m_ld_occ, m_last_ld, if_acc, ld_acc;
    logic [15:0] m_cnt;
    int          n_if_rsp = 0, n_ld_rsp = 0;

    always @(negedge clk) begin
        logic if_el, ld_el, g_if, g_ld;
        logic [31:0] exp_mem;
        if (rst) begin
            check("rst_if_ready", {63'b0, if_req_ready}, 64'd0);
            check("rst_ld_ready", {63'b0, ld_req_ready}, 64'd0);
            exp_if_q.delete();
            exp_ld_q.delete();
            m_if_occ  = 1'b0;
            m_ld_occ  = 1'b0;
            m_last_ld = 1'b1;
            m_cnt     = '0;
            if_acc    = 1'b0;
            ld_acc    = 1'b0;
        end else begin
            if_el = if_req_valid && (!m_if_occ || if_rsp_ready);
            ld_el = ld_req_valid && (!m_ld_occ || ld_rsp_ready);
            g_if  = if_el && (!ld_el || m_last_ld);
            g_ld  = ld_el && (!if_el || !m_last_ld);
            check("if_req_ready", {63'b0, if_req_ready}, {63'b0, g_if});
            check("ld_req_ready", {63'b0, ld_req_ready}, {63'b0, g_ld});
            check("if_rsp_valid", {63'b0, if_rsp_valid}, {63'b0, m_if_occ});
            check("ld_rsp_valid", {63'b0, ld_rsp_valid}, {63'b0, m_ld_occ});
            check("conflict_cnt", {48'b0, conflict_cnt}, {48'b0, m_cnt});
            if (m_if_occ) begin
                if (exp_if_q.size() == 0) check("if_q_size", 64'd0, 64'd1);
                else begin
                    check("if_rsp", {31'b0, if_rsp_err, if_rsp_data}, {31'b0, exp_if_q[0]});
                    if (if_rsp_ready) begin
                        void'(exp_if_q.pop_front());
                        n_if_rsp++;
                    end
                end
            end
            if (m_ld_occ) begin
                if (exp_ld_q.size() == 0) check("ld_q_size", 64'd0, 64'd1);
                else begin
                    check("ld_rsp", {31'b0, ld_rsp_err, ld_rsp_data}, {31'b0, exp_ld_q[0]});
                    if (ld_rsp_ready) begin
                        void'(exp_ld_q.pop_front());
                        n_ld_rsp++;
                    end
                end
            end
            exp_mem = 32'h0;
            if (g_if && addr_ok(if_req_addr)) exp_mem = if_req_addr;
            if (g_ld && addr_ok(ld_req_addr)) exp_mem = ld_req_addr;
            check("mem_addr", {32'b0, mem_addr}, {32'b0, exp_mem});
            // Advance the model to the state after the coming posedge
            if (g_if) exp_if_q.push_back(exp_rsp(if_req_addr));
            if (g_ld) exp_ld_q.push_back(exp_rsp(ld_req_addr));
            m_if_occ = g_if ? 1'b1 : (if_rsp_ready ? 1'b0 : m_if_occ);
            m_ld_occ = g_ld ? 1'b1 : (ld_rsp_ready ? 1'b0 : m_ld_occ);
            if (if_el && ld_el && m_cnt != 16'hFFFF) m_cnt = m_cnt + 1'b1;
            if (g_if) m_last_ld = 1'b0;
            if (g_ld) m_last_ld = 1'b1;
            if_acc = g_if;
            ld_acc = g_ld;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        int base_if, base_ld;
        logic [31:0] la [4];
        la[0] = 32'h8000_1000; la[1] = 32'h7FFF_FFFC;
        la[2] = 32'h8000_0002; la[3] = 32'h8000_0FFC;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Single IF fetch from the reset vector
        tick();
        if_req_valid = 1'b1; if_req_addr = 32'h8000_0000; if_rsp_ready = 1'b1;
        #1;
        check("t1_ready", {63'b0, if_req_ready}, 64'd1);
        check("t1_mem_addr", {32'b0, mem_addr}, 64'h8000_0000);
        tick();
        if_req_valid = 1'b0;
        #1;
        check("t1_rsp_valid", {63'b0, if_rsp_valid}, 64'd1);
        check("t1_rsp_data", {32'b0, if_rsp_data}, 64'h0000_0297);
        check("t1_rsp_err", {63'b0, if_rsp_err}, 64'd0);
        tick();

        // Continuous conflict: grants alternate, starting with IF
        do_reset();
        base_if = n_if_rsp; base_ld = n_ld_rsp;
        if_req_valid = 1'b1; if_req_addr = 32'h8000_0004;
        ld_req_valid = 1'b1; ld_req_addr = 32'h8000_0008;
        if_rsp_ready = 1'b1; ld_rsp_ready = 1'b1;
        #1;
        check("t2_first_if", {62'b0, if_req_ready, ld_req_ready}, 64'd2);
        repeat (6) tick();
        if_req_valid = 1'b0; ld_req_valid = 1'b0;
        #1;
        check("t2_conflicts", {48'b0, conflict_cnt}, 64'd6);
        repeat (2) tick();
        check("t2_if_count", 64'(n_if_rsp - base_if), 64'd3);
        check("t2_ld_count", 64'(n_ld_rsp - base_ld), 64'd3);

        // LD range and alignment faults, then the last valid word
        for (int i = 0; i < 4; i++) begin
            ld_req_valid = 1'b1; ld_req_addr = la[i];
            #1;
            check("t3_ready", {63'b0, ld_req_ready}, 64'd1);
            check("t3_mem_addr", {32'b0, mem_addr}, (i < 3) ? 64'd0 : {32'b0, la[i]});
            tick();
            check("t3_err", {63'b0, ld_rsp_err}, (i < 3) ? 64'd1 : 64'd0);
            check("t3_data", {32'b0, ld_rsp_data}, (i < 3) ? 64'd0 : {32'b0, rom_word(la[i])});
        end
        ld_req_valid = 1'b0;
        tick();

        // IF response stalled while LD keeps streaming
        if_req_valid = 1'b1; if_req_addr = 32'h8000_0010; if_rsp_ready = 1'b0;
        ld_req_valid = 1'b1; ld_req_addr = 32'h8000_0020; ld_rsp_ready = 1'b1;
        tick();
        if_req_addr = 32'h8000_0014;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("t4_if_ready", {63'b0, if_req_ready}, 64'd0);
            check("t4_if_hold", {32'b0, if_rsp_data}, {32'b0, rom_word(32'h8000_0010)});
            check("t4_ld_ready", {63'b0, ld_req_ready}, 64'd1);
            tick();
            ld_req_addr = ld_req_addr + 32'd4;
        end
        if_rsp_ready = 1'b1;
        #1;
        check("t4_drain_accept", {63'b0, if_req_ready}, 64'd1);
        tick();
        if_req_valid = 1'b0; ld_req_valid = 1'b0;
        #1;
        check("t4_new_data", {32'b0, if_rsp_data}, {32'b0, rom_word(32'h8000_0014)});
        tick();

        // Constrained-random traffic; requests held until accepted
        for (int c = 0; c < 80; c++) begin
            if (!if_req_valid || if_acc) begin
                if_req_valid = 1'($urandom_range(0, 1));
                if_req_addr  = pick_addr();
            end
            if (!ld_req_valid || ld_acc) begin
                ld_req_valid = 1'($urandom_range(0, 1));
                ld_req_addr  = pick_addr();
            end
            if_rsp_ready = ($urandom_range(0, 3) != 0);
            ld_rsp_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        while (if_req_valid && !if_acc) tick();
        if_req_valid = 1'b0;
        while (ld_req_valid && !ld_acc) tick();
        ld_req_valid = 1'b0;
        if_rsp_ready = 1'b1; ld_rsp_ready = 1'b1;
        repeat (3) tick();

        // Reset with both responses held and both requests pending
        if_rsp_ready = 1'b0; ld_rsp_ready = 1'b0;
        if_req_valid = 1'b1; if_req_addr = 32'h8000_0100;
        ld_req_valid = 1'b1; ld_req_addr = 32'h8000_0200;
        repeat (2) tick();
        check("t5_both_held", {62'b0, if_rsp_valid, ld_rsp_valid}, 64'd3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check("t5_rsp_cleared", {62'b0, if_rsp_valid, ld_rsp_valid}, 64'd0);
        check("t5_cnt_cleared", {48'b0, conflict_cnt}, 64'd0);
        check("t5_if_wins", {62'b0, if_req_ready, ld_req_ready}, 64'd2);
        tick();
        if_req_valid = 1'b0; ld_req_valid = 1'b0;
        if_rsp_ready = 1'b1; ld_rsp_ready = 1'b1;
        repeat (3) tick();

        // Saturating counter on the narrow instance
        if_req_valid2 = 1'b1; ld_req_valid2 = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            tick();
            check("t6_cnt_sat", {62'b0, conflict_cnt2}, (k < 3) ? 64'(k) : 64'd3);
        end
        if_req_valid2 = 1'b0; ld_req_valid2 = 1'b0;
        repeat (2) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
